// File: rtl/uart_im_loader.sv
// uart_im_loader: receives a program image over an 8N1 UART line and writes it
// into instruction memory as little-endian 32-bit words at consecutive word
// addresses. While loading is enabled the CPU is held so it never fetches from
// a half-written program.
//
// Handshake: im_we is a single-cycle write strobe in the clk domain. im_a and
// im_d are valid in the same cycle as im_we and hold their values between
// writes. There is no back-pressure; the memory accepts every strobe.
module uart_im_loader #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_a,
  output logic [31:0]       im_d,
  output logic              cpu_hold,
  output logic              busy,
  output logic [ADDR_W:0]   word_cnt,
  output logic              frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(1 << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  rx_state_t      state, state_nxt;
  logic           rx_meta, rx_s;
  logic           ld_meta, ld_s;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic [1:0]     byte_idx;
  logic [31:0]    word;
  logic           cnt_clr, bit_take, byte_ok, stop_bad;
  logic           ld_rise;

  // cpu_hold is ld_s delayed by one clock, so it doubles as the edge-detect history.
  assign ld_rise = ld_s & ~cpu_hold;
  assign busy    = (state != S_IDLE);

  // Two-flop synchronizers; the serial line idles high, the load switch idles low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      ld_meta  <= 1'b0;
      ld_s     <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_s     <= rx_meta;
      ld_meta  <= load_en;
      ld_s     <= ld_meta;
      cpu_hold <= ld_s;
    end
  end

  // RX FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // RX FSM next state and per-cycle strobes.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_take  = 1'b0;
    byte_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
          if (rx_s) byte_ok  = 1'b1;
          else      stop_bad = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-time counter, bit index and shift register for the RX datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (state == S_IDLE || cnt_clr) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
      if (state == S_START)  bit_idx <= 3'd0;
      else if (bit_take)     bit_idx <= bit_idx + 3'd1;
      if (bit_take) shreg[bit_idx] <= rx_s;
    end
  end

  // Word assembly and memory write; a falling load drops any partial word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      im_we    <= 1'b0;
      im_a     <= '0;
      im_d     <= 32'd0;
      word_cnt <= '0;
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else begin
      im_we <= 1'b0;
      if (ld_rise) begin
        im_a     <= '0;
        word_cnt <= '0;
        byte_idx <= 2'd0;
        word     <= 32'd0;
      end else begin
        if (im_we) begin
          im_a <= im_a + ADDR_W'(1);
          if (word_cnt != CNT_FULL) word_cnt <= word_cnt + (ADDR_W + 1)'(1);
        end
        if (!ld_s) begin
          byte_idx <= 2'd0;
        end else if (byte_ok) begin
          word[byte_idx*8 +: 8] <= shreg;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            im_we <= 1'b1;
            im_d  <= {shreg, word[23:0]};
          end
        end
      end
    end
  end

  // Sticky framing error, cleared when a new load starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         frame_err <= 1'b0;
    else if (stop_bad) frame_err <= 1'b1;
    else if (ld_rise)  frame_err <= 1'b0;
  end

endmodule

// File: tb/tb_uart_im_loader.sv
// Directed bench for uart_im_loader: one 64-word instance for most cases and a
// 4-word instance (separate load switch) for address wrap.
`timescale 1ns/1ps
module tb_uart_im_loader;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        load_en = 1'b0;
  logic        ld_w = 1'b0;

  logic        im_we;
  logic [5:0]  im_a;
  logic [31:0] im_d;
  logic        cpu_hold, busy, frame_err;
  logic [6:0]  word_cnt;

  logic        w_im_we;
  logic [1:0]  w_im_a;
  logic [31:0] w_im_d;
  logic        w_cpu_hold, w_busy, w_frame_err;
  logic [2:0]  w_word_cnt;

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q[$];
  logic [33:0] expw_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_im_loader #(.CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(6)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .load_en(load_en),
    .im_we(im_we), .im_a(im_a), .im_d(im_d), .cpu_hold(cpu_hold),
    .busy(busy), .word_cnt(word_cnt), .frame_err(frame_err)
  );

  uart_im_loader #(.CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(2)) dut_w (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .load_en(ld_w),
    .im_we(w_im_we), .im_a(w_im_a), .im_d(w_im_d), .cpu_hold(w_cpu_hold),
    .busy(w_busy), .word_cnt(w_word_cnt), .frame_err(w_frame_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [37:0] e;
    if (rstn && im_we) begin
      if (exp_q.size() == 0) check("unexpected_we", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_a), 64'(e[37:32]));
        check("wr_data", 64'(im_d), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (rstn && w_im_we) begin
      if (expw_q.size() == 0) check("w_unexpected_we", 64'd1, 64'd0);
      else begin
        e = expw_q.pop_front();
        check("w_wr_addr", 64'(w_im_a), 64'(e[33:32]));
        check("w_wr_data", 64'(w_im_d), 64'(e[31:0]));
      end
    end
  end

  // driver tasks (all start and end on a falling clock edge)
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2*CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic restart_load();
    load_en = 1'b0;
    repeat (6) @(negedge clk);
    load_en = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_we"},   64'(im_we), 64'd0);
    check({pfx, "_a"},    64'(im_a), 64'd0);
    check({pfx, "_d"},    64'(im_d), 64'd0);
    check({pfx, "_hold"}, 64'(cpu_hold), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_cnt"},  64'(word_cnt), 64'd0);
    check({pfx, "_ferr"}, 64'(frame_err), 64'd0);
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wr [5];
    wr[0] = 32'h03020100; wr[1] = 32'h07060504; wr[2] = 32'h0B0A0908;
    wr[3] = 32'h0F0E0D0C; wr[4] = 32'h13121110;

    // reset state
    #12;
    check_all_zero("rst");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // single word, plus cpu_hold latency of three clocks
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("hold_lat2", 64'(cpu_hold), 64'd0);
    @(posedge clk);
    #1 check("hold_lat3", 64'(cpu_hold), 64'd1);
    repeat (4) @(negedge clk);
    exp_q.push_back({6'd0, 32'h00500513});
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
    check("t1_cnt", 64'(word_cnt), 64'd1);
    check("t1_a", 64'(im_a), 64'd1);
    check("t1_ferr", 64'(frame_err), 64'd0);
    check("t1_d_hold", 64'(im_d), 64'h00500513);
    check("t1_q", 64'(exp_q.size()), 64'd0);

    // three words
    restart_load();
    check("t2_a_clr", 64'(im_a), 64'd0);
    exp_q.push_back({6'd0, 32'h00000013});
    exp_q.push_back({6'd1, 32'h00100093});
    exp_q.push_back({6'd2, 32'hFFF00113});
    send_word(32'h00000013);
    check("t2_hold0", 64'(cpu_hold), 64'd1);
    send_word(32'h00100093);
    check("t2_hold1", 64'(cpu_hold), 64'd1);
    send_word(32'hFFF00113);
    check("t2_hold2", 64'(cpu_hold), 64'd1);
    check("t2_cnt", 64'(word_cnt), 64'd3);
    check("t2_a", 64'(im_a), 64'd3);
    check("t2_q", 64'(exp_q.size()), 64'd0);

    // framing error is sticky and the bad byte is dropped
    restart_load();
    send_byte(8'hAA, 1'b0);
    check("t3_ferr_set", 64'(frame_err), 64'd1);
    exp_q.push_back({6'd0, 32'h04030201});
    send_word(32'h04030201);
    check("t3_ferr_stay", 64'(frame_err), 64'd1);
    check("t3_cnt", 64'(word_cnt), 64'd1);
    check("t3_q", 64'(exp_q.size()), 64'd0);

    // load gating and partial word
    load_en = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_hold_off", 64'(cpu_hold), 64'd0);
    send_word(32'h12345678);
    check("t4_hold_off2", 64'(cpu_hold), 64'd0);
    load_en = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_ferr_clr", 64'(frame_err), 64'd0);
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
    load_en = 1'b0;
    repeat (10) @(negedge clk);
    load_en = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.push_back({6'd0, 32'h44332211});
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    check("t4_cnt", 64'(word_cnt), 64'd1);
    check("t4_a", 64'(im_a), 64'd1);
    check("t4_q", 64'(exp_q.size()), 64'd0);

    // address wrap on the 4-word instance
    load_en = 1'b0;
    ld_w = 1'b1;
    repeat (6) @(negedge clk);
    expw_q.push_back({2'd0, wr[0]});
    expw_q.push_back({2'd1, wr[1]});
    expw_q.push_back({2'd2, wr[2]});
    expw_q.push_back({2'd3, wr[3]});
    expw_q.push_back({2'd0, wr[4]});
    for (int i = 0; i < 5; i++) send_word(wr[i]);
    check("t5_cnt_sat", 64'(w_word_cnt), 64'd4);
    check("t5_a", 64'(w_im_a), 64'd1);
    check("t5_q", 64'(expw_q.size()), 64'd0);
    ld_w = 1'b0;

    // glitch on the line
    load_en = 1'b1;
    repeat (6) @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_busy_glitch", 64'(busy), 64'd1);
    repeat (15) @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);
    check("t6_cnt", 64'(word_cnt), 64'd0);
    check("t6_ferr", 64'(frame_err), 64'd0);

    // reset in the middle of a frame, with one byte already latched
    send_byte(8'h5A, 1'b1);
    uart_rx = 1'b0;
    repeat (CPB + 35) @(negedge clk);
    check("t7_busy_pre", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1 check_all_zero("t7_rst");
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back({6'd0, 32'hCAFEBABE});
    send_word(32'hCAFEBABE);
    check("t7_cnt", 64'(word_cnt), 64'd1);
    check("t7_a", 64'(im_a), 64'd1);
    check("t7_q", 64'(exp_q.size()), 64'd0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_im_loader.md
Name: uart_im_loader

Overview:
- Board-side writer for the instruction memory.
- Receives a program image over UART (8N1, LSB first) and packs every 4 bytes little-endian into one 32-bit word.
- Writes each word into consecutive instruction-memory word addresses, using the same word indexing the CPU uses for fetch (PC[7:2]).
- While loading is enabled it asserts a hold to the CPU, so the PC does not advance on a partially written program.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- ADDR_W, 6, word-address width of the instruction memory (64 words).
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, derived), clocks per UART bit.

Ports:
- clk  input  1  system clock (board clock, not the divided CPU clock).
- rstn  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- load_en  input  1  load mode request (board switch), asynchronous.
- im_we  output  1  instruction-memory write strobe, one clk pulse per word.
- im_a  output  ADDR_W  instruction-memory word address.
- im_d  output  32  instruction-memory write data.
- cpu_hold  output  1  high while loading; CPU must not update PC.
- busy  output  1  high while the RX FSM is not in IDLE.
- word_cnt  output  ADDR_W+1  words written since the last load start; saturates at 2^ADDR_W.
- frame_err  output  1  sticky framing-error flag.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, FSM in IDLE, byte index 0, address 0, synchronizers at 1 for uart_rx and 0 for load_en.
- Synchronization: uart_rx and load_en each pass through a 2-flop synchronizer. All further logic uses the synchronized versions, called rx_s and ld_s.
- cpu_hold: equals ld_s, registered, so it has 3 clk latency from load_en.
- Load start (rising edge of ld_s):
  - im_a, byte index, word_cnt and frame_err cleared to 0.
  - The partial-word register is cleared.
- Load end (ld_s falling):
  - Any partial word (1-3 bytes) is discarded.
  - An RX frame in progress finishes, and its byte is dropped.
- RX FSM states:
  - IDLE: rx_s=0 -> START, counter reset.
  - START: after CLKS_PER_BIT/2 clocks, sample rx_s. If it is 0 -> DATA with bit index 0; if it is 1 (glitch) -> IDLE.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into bit[index], LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s. If it is 1, the byte is valid (a 1-cycle internal pulse). If it is 0, set frame_err and drop the byte. Either way -> IDLE.
- Byte assembly (only when ld_s=1):
  - A valid byte k (k=0..3) is placed in word bits [8k+7:8k].
  - When k=3 completes the word, in the next cycle: im_we=1 for exactly one clk, im_d = assembled word, im_a = current address.
  - After that cycle, im_a increments and word_cnt increments (saturating).
- Bytes received while ld_s=0 are discarded and no write occurs.
- Address wrap: after address 2^ADDR_W-1, im_a wraps to 0 and later words overwrite earlier ones. word_cnt stays at 2^ADDR_W.
- im_a and im_d hold their values between writes. im_we is 0 except on the write cycle.
- busy is 1 in START, DATA and STOP.
- Write timing to the CPU clock domain: im_we is a clk-domain pulse. The memory write port is on clk, and the CPU is held by cpu_hold, so no CDC handshake is required.
- Reset mid-frame returns to IDLE immediately. The next start bit is detected normally.

Test Plan:
Bench setup: CLK_FREQ=1000000, BAUD=100000, giving CLKS_PER_BIT=10.
- Single word: load_en=1, send bytes 0x13,0x05,0x50,0x00 -> exactly one im_we pulse with im_a=0, im_d=0x00500513; then word_cnt=1, im_a=1, frame_err=0.
- Three words: send 12 bytes forming 0x00000013, 0x00100093, 0xFFF00113 -> im_we pulses at im_a=0,1,2 with those data; word_cnt=3; cpu_hold=1 throughout.
- Framing error: send byte 0xAA with stop bit driven 0, then 4 good bytes 0x01,0x02,0x03,0x04 -> frame_err=1 and stays set; one write with im_d=0x04030201 at im_a=0.
- Load gating and partial word:
  - With load_en=0, send 4 bytes -> no im_we and cpu_hold=0.
  - Raise load_en, send 2 bytes, drop load_en, raise it again, send 4 bytes 0x11,0x22,0x33,0x44 -> single write im_a=0, im_d=0x44332211.
- Wrap: with ADDR_W=2, send 5 words -> writes at im_a=0,1,2,3,0; word_cnt=4 (saturated).
- Glitch and reset:
  - 3-clk low pulse on uart_rx -> FSM returns to IDLE with no byte received.
  - Assert rstn=0 mid-DATA -> all outputs 0 immediately; after release, a clean 4-byte word writes correctly at im_a=0.
